// File: rtl/clk_div_if.sv
// rtl/clk_div_if.sv - control and output bundle for the multi-channel clock divider
interface clk_div_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 32
);
    logic                    sync;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*CNT_W-1:0] div_half;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;

    modport master (
        output sync,
        output en,
        output div_half,
        input  clk_out,
        input  tick
    );

    modport slave (
        input  sync,
        input  en,
        input  div_half,
        output clk_out,
        output tick
    );
endinterface

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - NUM_CH independent programmable clock dividers with tick outputs
// CLKDIV_SIM_FAST_EN: half-period values are right-shifted by SIM_SHIFT for fast simulation
module clk_div_multi #(
    parameter int NUM_CH    = 3,
    parameter int CNT_W     = 32,
    parameter int SIM_SHIFT = 16
) (
    input  logic      clk_50m,
    input  logic      cr,
    clk_div_if.slave  bus
);

`ifdef CLKDIV_SIM_FAST_EN
    localparam bit SIM_FAST = 1'b1;
`else
    localparam bit SIM_FAST = 1'b0;
`endif

    localparam int EFF_SHIFT = SIM_FAST ? SIM_SHIFT : 0;

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            logic [CNT_W-1:0] cnt;
            logic [CNT_W-1:0] per_q;
            logic [CNT_W-1:0] div_eff;
            logic [CNT_W-1:0] cmp;
            logic             load_pend;
            logic             clk_q;
            logic             tick_q;
            logic             term;

            assign div_eff = bus.div_half[i*CNT_W +: CNT_W] >> EFF_SHIFT;
            // Until the first enabled cycle after reset/sync the live input is the compare value.
            assign cmp     = load_pend ? div_eff : per_q;
            assign term    = (cnt == cmp);

            always_ff @(posedge clk_50m or negedge cr) begin
                if (!cr) begin
                    cnt       <= '0;
                    per_q     <= '0;
                    load_pend <= 1'b1;
                    clk_q     <= 1'b0;
                    tick_q    <= 1'b0;
                end else if (bus.sync) begin
                    cnt       <= '0;
                    per_q     <= '0;
                    load_pend <= 1'b1;
                    clk_q     <= 1'b0;
                    tick_q    <= 1'b0;
                end else if (!bus.en[i]) begin
                    tick_q    <= 1'b0;
                end else if (term) begin
                    cnt       <= '0;
                    clk_q     <= ~clk_q;
                    per_q     <= div_eff;
                    load_pend <= 1'b0;
                    tick_q    <= ~clk_q;
                end else begin
                    cnt       <= cnt + CNT_W'(1);
                    tick_q    <= 1'b0;
                    if (load_pend) begin
                        per_q     <= div_eff;
                        load_pend <= 1'b0;
                    end
                end
            end

            assign bus.clk_out[i] = clk_q;
            assign bus.tick[i]    = tick_q;
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - randomized and directed bench for clk_div_multi against a half-period model
module tb_clk_div_multi;
    localparam int NUM_CH    = 3;
    localparam int CNT_W     = 32;
    localparam int SIM_SHIFT = 16;

    logic clk_50m = 1'b0;
    logic cr      = 1'b0;
    always #5 clk_50m = ~clk_50m;

    clk_div_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SIM_SHIFT(SIM_SHIFT)) dut (
        .clk_50m (clk_50m),
        .cr      (cr),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Model: each half-period is a run of len enabled cycles; len is fixed when the run starts.
    longint unsigned m_len     [NUM_CH];
    longint unsigned m_elapsed [NUM_CH];
    bit              m_fresh   [NUM_CH];
    bit              m_lvl     [NUM_CH];
    bit              m_tick    [NUM_CH];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint unsigned eff(input longint unsigned n);
`ifdef CLKDIV_SIM_FAST_EN
        return n >> SIM_SHIFT;
`else
        return n;
`endif
    endfunction

    function automatic longint unsigned n_of(input int c);
        return longint'(bus.div_half[c*CNT_W +: CNT_W]);
    endfunction

    task automatic set_n(input int c, input logic [CNT_W-1:0] v);
        bus.div_half[c*CNT_W +: CNT_W] = v;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_len[c]     = 0;
            m_elapsed[c] = 0;
            m_fresh[c]   = 1'b1;
            m_lvl[c]     = 1'b0;
            m_tick[c]    = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (bus.sync) begin
            model_reset();
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!bus.en[c]) begin
                    m_tick[c] = 1'b0;
                end else begin
                    if (m_fresh[c]) begin
                        m_len[c]   = eff(n_of(c)) + 1;
                        m_fresh[c] = 1'b0;
                    end
                    m_elapsed[c]++;
                    if (m_elapsed[c] == m_len[c]) begin
                        m_lvl[c]     = !m_lvl[c];
                        m_tick[c]    = m_lvl[c];
                        m_elapsed[c] = 0;
                        m_len[c]     = eff(n_of(c)) + 1;
                    end else begin
                        m_tick[c] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        for (int c = 0; c < NUM_CH; c++) begin
            check_eq($sformatf("clk_out%0d@%0d", c, edge_n), 64'(bus.clk_out[c]), 64'(m_lvl[c]));
            check_eq($sformatf("tick%0d@%0d", c, edge_n), 64'(bus.tick[c]), 64'(m_tick[c]));
        end
    endtask

    task automatic step();
        @(posedge clk_50m);
        model_edge();
        edge_n++;
        @(negedge clk_50m);
        compare();
    endtask

    task automatic do_sync();
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        edge_n = 0;
    endtask

    // Release (or already released) reset with N={24999,1,0}; called on a falling edge.
    task automatic run_base(input string tag);
        int first_rise;
        int t1;
        int t2;
        longint unsigned exp0;
        longint unsigned p1;
        longint unsigned e_total;
        set_n(0, 32'd24999);
        set_n(1, 32'd1);
        set_n(2, 32'd0);
        bus.en   = 3'b111;
        bus.sync = 1'b0;
        cr       = 1'b1;
        edge_n   = 0;
        first_rise = 0;
        t1 = 0;
        t2 = 0;
        exp0    = eff(24999) + 1;
        e_total = exp0 + 8;
        while (edge_n < int'(e_total)) begin
            step();
            if (first_rise == 0 && bus.clk_out[0]) first_rise = edge_n;
            if (bus.tick[1]) t1++;
            if (bus.tick[2]) t2++;
        end
        p1 = 2 * (eff(1) + 1);
        check_eq({tag, "_ch0_first_rise"}, 64'(first_rise), exp0);
        check_eq({tag, "_ch1_ticks"}, 64'(t1), (e_total + p1 / 2) / p1);
        check_eq({tag, "_ch2_ticks"}, 64'(t2), (e_total + 1) / 2);
    endtask

    initial begin
        int tog[$];
        int prev;
        int rise;
        longint unsigned h;
        bus.sync     = 1'b0;
        bus.en       = '0;
        bus.div_half = '0;
        cr           = 1'b0;
        model_reset();

        repeat (2) @(negedge clk_50m);
        check_eq("reset_clk_out", 64'(bus.clk_out), 64'd0);
        check_eq("reset_tick", 64'(bus.tick), 64'd0);

        run_base("s1");

        // Mid-half-period reprogramming must not disturb the running half-period.
        set_n(1, 32'd249);
        do_sync();
        prev = 0;
        while (edge_n < 520) begin
            if (edge_n == 100) set_n(1, 32'd124);
            step();
            if (int'(bus.clk_out[1]) != prev) tog.push_back(edge_n);
            prev = int'(bus.clk_out[1]);
        end
        check_eq("s2_toggle_count_ge3", 64'(tog.size() >= 3), 64'd1);
        if (tog.size() >= 3) begin
            check_eq("s2_first_half", 64'(tog[0]), eff(249) + 1);
            check_eq("s2_second_half", 64'(tog[1] - tog[0]), eff(124) + 1);
            check_eq("s2_third_half", 64'(tog[2] - tog[1]), eff(124) + 1);
        end

        // Enable gap stretches the half-period by the gap length.
        set_n(0, 32'd3);
        bus.en = 3'b111;
        do_sync();
        rise = 0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 3) bus.en[0] = 1'b0;
            if (k == 8) bus.en[0] = 1'b1;
            step();
            if (rise == 0 && bus.clk_out[0]) rise = edge_n;
        end
        h = eff(3) + 1;
        check_eq("s3_stretched_rise", 64'(rise), (h > 2) ? h + 5 : h);

        // Scatter phases, then realign.
        for (int c = 0; c < NUM_CH; c++) set_n(c, CNT_W'($urandom_range(0, 5)));
        for (int k = 0; k < 300; k++) begin
            bus.en = NUM_CH'($urandom);
            step();
        end
        bus.en = 3'b111;
        do_sync();
        check_eq("s4_sync_clk_out", 64'(bus.clk_out), 64'd0);
        check_eq("s4_sync_tick", 64'(bus.tick), 64'd0);
        for (int c = 0; c < NUM_CH; c++) set_n(c, 32'd3);
        h = eff(3) + 1;
        for (int k = 0; k < 40; k++) begin
            step();
            check_eq($sformatf("s4_aligned@%0d", edge_n), 64'(bus.clk_out),
                     (((longint'(edge_n) / h) % 2) == 1) ? 64'd7 : 64'd0);
        end

        // Random traffic with occasional reprogramming and sync.
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 9) == 0) set_n(c, CNT_W'($urandom_range(0, 6)));
                bus.en[c] = ($urandom_range(0, 3) != 0);
            end
            bus.sync = ($urandom_range(0, 49) == 0);
            step();
        end
        bus.sync = 1'b0;

        // Asynchronous reset between edges clears outputs immediately.
        bus.en = 3'b111;
        for (int c = 0; c < NUM_CH; c++) set_n(c, 32'd0);
        @(posedge clk_50m);
        #2 cr = 1'b0;
        model_reset();
        #1;
        check_eq("s5_async_clk_out", 64'(bus.clk_out), 64'd0);
        check_eq("s5_async_tick", 64'(bus.tick), 64'd0);
        @(negedge clk_50m);
        run_base("s5");

`ifdef CLKDIV_SIM_FAST_EN
        set_n(0, 32'd24999999);
        bus.en = 3'b111;
        do_sync();
        tog.delete();
        while (edge_n < 2000) begin
            step();
            if (bus.tick[0]) tog.push_back(edge_n);
        end
        check_eq("s6_tick_count_ge2", 64'(tog.size() >= 2), 64'd1);
        if (tog.size() >= 2) begin
            check_eq("s6_first_tick", 64'(tog[0]), 64'd382);
            check_eq("s6_tick_spacing", 64'(tog[1] - tog[0]), 64'd764);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock divider/tick generator for the digital-clock datapath. It replaces fixed per-rate dividers with NUM_CH independent channels driven from the board clock. Each channel has a runtime-programmable half-period, an enable, a global phase-realign, and a square-wave output plus a single-cycle tick. Consumers are the timekeeping counters (1 Hz), blink logic (2 Hz) and display scan (1 kHz).

## Interface
- NUM_CH, 3, number of independent divider channels (≥1)
- CNT_W, 32, counter and half-period width in bits (≥1)
- SIM_SHIFT, 16, right-shift applied to half-period values when CLKDIV_SIM_FAST_EN is defined
- clk_50m  input  1  system clock, all logic on rising edge
- cr  input  1  asynchronous active-low reset
- sync  input  1  synchronous realign; restarts all channels in phase
- en  input  NUM_CH  per-channel count enable
- div_half  input  NUM_CH*CNT_W  per-channel half-period value N; channel i in bits [i*CNT_W +: CNT_W]
- clk_out  output  NUM_CH  per-channel divided square wave, registered
- tick  output  NUM_CH  one-cycle pulse, high on the cycle clk_out[i] rises, registered

## Operation
- Per channel state: cnt[CNT_W], per_q[CNT_W] (shadow half-period), load_pend, clk_out, tick.
- Half-period = N+1 enabled cycles; full period = 2(N+1). N=0 gives divide-by-2.
- Compare value cmp = load_pend ? div_half_i : per_q.
- Priority per cycle: cr (async) > sync > en.
- cr low: cnt=0, per_q=0, load_pend=1, clk_out=0, tick=0 for all channels.
- sync high: same values as reset, applied synchronously to all channels regardless of en.
- en_i low: cnt, per_q, clk_out, load_pend hold; tick_i=0.
- en_i high, cnt==cmp (terminal): cnt←0, clk_out←~clk_out, per_q←div_half_i, load_pend←0, tick←~clk_out (i.e. 1 only on rising toggle).
- en_i high, not terminal: cnt←cnt+1, tick←0; if load_pend then per_q←div_half_i, load_pend←0.
- div_half changes take effect only at the next half-period boundary (captured into per_q); a value written mid-half-period never truncates or extends the current half-period, even if below current cnt.
- Channels fully independent except for shared sync and reset.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- After cr release or sync, with en continuously high and N constant: clk_out rises on the (N+1)th enabled edge, falls on the 2(N+1)th, repeating; tick high for exactly the cycle clk_out reads 1 for the first time each period.
- Disabling en stretches the current half-period by the number of disabled cycles; no toggle, no tick while disabled.
- sync asserted on same cycle as a terminal count: sync wins, no toggle, no tick.
- cnt never exceeds per_q; no wrap-around of cnt possible. N=2^CNT_W−1 is legal.

## Configuration
- CLKDIV_SIM_FAST_EN defined: every value captured into per_q/compared via cmp is div_half_i >> SIM_SHIFT (e.g. 24999999 → 381), for fast simulation with production constants.
- Not defined: div_half_i used unmodified. No other behaviour differs.

## Test plan
- Reset, en=3'b111, N={24999, 1, 0} (macro off, CNT_W=32): ch2 toggles every cycle, ch1 period 4 cycles with tick every 4th cycle, ch0 first rise at edge 25000.
- ch1 N=249, change N to 124 at cycle 100: first half-period still 250 cycles, subsequent half-periods 125.
- ch0 N=3, drop en for 5 cycles mid-half-period: that half-period lasts 9 clocks, tick count unchanged, no output glitch.
- Run all channels to arbitrary phases, pulse sync 1 cycle: all clk_out=0, tick=0 next cycle; with equal N all channels subsequently identical.
- Assert cr mid-period asynchronously (between edges): clk_out and tick go 0 immediately; restart matches first scenario.
- Macro on, SIM_SHIFT=16, N=24999999: half-period 382 cycles, tick every 764 cycles.
